eth_txsched: RTL and testbench
==============================

// Module: eth_txsched
// PURPOSE
//  Packet-aware round-robin scheduler between the two PCIe tap FIFOs (CQ tap = src0, CC tap = src1)
//  and the single arb2encap FIFO feeding eth_encap, all in the clk156 domain.
//  Grants one source per packet and holds the grant until that packet's last word.
//  Guards the encapsulator against runaway packets by truncating at MAX_WORDS and discarding the tail.
// PARAMETERS
//  DATA_W     64    data bits per word
//  KEEP_W     8     byte-enable bits per word
//  WORD_W     74    FIFO word width = DATA_W+KEEP_W+2
//  MAX_WORDS  1024  max words per packet before forced truncation; >=2
//  CNT_W      32    width of statistics counters
// PORTS
//  clk156       in   1       core clock (156.25 MHz)
//  sys_rst_n    in   1       async assert, active-low reset
//  fifo0_dout   in   WORD_W  src0 FWFT head word
//  fifo0_empty  in   1       src0 empty
//  fifo0_rd_en  out  1       src0 pop
//  fifo1_dout   in   WORD_W  src1 FWFT head word
//  fifo1_empty  in   1       src1 empty
//  fifo1_rd_en  out  1       src1 pop
//  wr_en        out  1       push to arb2encap FIFO
//  din          out  WORD_W  word pushed
//  full         in   1       arb2encap FIFO full
//  pkt_cnt0     out  CNT_W   packets forwarded from src0
//  pkt_cnt1     out  CNT_W   packets forwarded from src1
//  trunc_cnt    out  16      packets truncated (either source)
//  busy         out  1       state != IDLE
// BEHAVIOUR
//  Word layout: [63:0] data, [71:64] keep, [72] last, [73] user(error). Sources are FWFT: head valid while !empty.
//  Reset (async on sys_rst_n low): state=IDLE, rr_ptr=0, wcnt=0, counters=0. rd_en/wr_en/busy=0 while in reset.
//  FSM IDLE: if exactly one source non-empty, grant it. If both non-empty, grant src[rr_ptr].
//   Grant is registered, so a packet's first pop occurs the cycle after IDLE (one bubble cycle per packet).
//   If neither source is non-empty, stay in IDLE.
//  FSM XFER: beat = !src_empty && !full. On beat: src_rd_en=1 and wr_en=1 in the same cycle (combinational),
//   din = head word, wcnt++.
//   - head.last=1: go IDLE, rr_ptr = ~grant, pkt_cntN++, wcnt=0.
//   - wcnt==MAX_WORDS-1 and head.last=0: din.last=1, din.user=1 forced; trunc_cnt++; go DRAIN.
//   - src empty or full: no pop, no push; hold state. Stalls never drop or duplicate words.
//  FSM DRAIN: pop granted source whenever !empty, ignoring full, wr_en=0, until a word with last=1 is popped.
//   Then go IDLE, rr_ptr = ~grant, wcnt=0.
//  The non-granted rd_en is always 0. Pops and pushes are never issued to both sources in one cycle.
//  Counters: pkt_cnt0/pkt_cnt1 wrap modulo 2^CNT_W; trunc_cnt saturates at 16'hFFFF.
//   A truncated packet counts in trunc_cnt only.
//  Reset mid-packet: the output stream may hold an unterminated packet. The arb2encap FIFO shares the same reset
//   source, so no recovery logic is required here.
// CONFIGURATION
//  ETH_TXSCHED_STATS_EN defined: pkt_cnt0/pkt_cnt1/trunc_cnt implemented as above.
//  Undefined: counter registers are not built; the three ports are tied to 0. Scheduling is unchanged.
// STRUCTURE
//  eth_pkg: eth_word_t packed struct {user, last, keep[7:0], data[63:0]}; typedef enum
//   sched_state_t {IDLE, XFER, DRAIN}; localparam ETH_WORD_W=74.
//  One sub-module, eth_txsched_rr (2-way round-robin pick: req[1:0], ptr -> grant, valid), combinational.
//  The FSM, word counter and stats live in eth_txsched.
// TESTING
//  1. src0 holds a 3-word pkt, src1 empty -> IDLE 1 cycle, then 3 consecutive pushes.
//     Last push has din[72]=1. pkt_cnt0=1, rr_ptr=1.
//  2. Both sources hold 2-word pkts, after reset -> output order src0 pkt, src1 pkt, with a one-cycle gap between them.
//     pkt_cnt0=pkt_cnt1=1.
//  3. full asserted for 5 cycles mid-packet -> no rd_en/wr_en during those cycles.
//     Resumes with the next word; no loss or duplication (scoreboard match).
//  4. MAX_WORDS=4, src1 pkt of 7 words -> 4 words out, 4th has last=1 and user=1.
//     The remaining 3 words are popped with wr_en=0. trunc_cnt=1, pkt_cnt1=0.
//  5. sys_rst_n pulsed low mid-XFER -> rd_en/wr_en drop immediately, state=IDLE, counters=0.
//     After release, the next packet from rr_ptr=0 is forwarded.
//  6. Build without ETH_TXSCHED_STATS_EN, rerun scenario 2 -> identical output stream; pkt_cnt0/1 and trunc_cnt read 0.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared types for the Ethernet TX scheduler slice.
// Word layout, FSM encoding and the FIFO word width.
package eth_pkg;

  localparam int ETH_WORD_W = 74;

  typedef struct packed {
    logic       user;
    logic       last;
    logic [7:0] keep;
    logic [63:0] data;
  } eth_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

endpackage

// File: rtl/eth_txsched_if.sv
// FIFO-side bundle of eth_txsched: two FWFT tap sources, one sink.
// master = scheduler, slave = the FIFOs.
interface eth_txsched_if
  import eth_pkg::*;
#(
  parameter int WORD_W = ETH_WORD_W
);

  logic [WORD_W-1:0] fifo0_dout;
  logic              fifo0_empty;
  logic              fifo0_rd_en;
  logic [WORD_W-1:0] fifo1_dout;
  logic              fifo1_empty;
  logic              fifo1_rd_en;
  logic              wr_en;
  logic [WORD_W-1:0] din;
  logic              full;

  modport master (
    input  fifo0_dout, fifo0_empty,
    input  fifo1_dout, fifo1_empty,
    input  full,
    output fifo0_rd_en, fifo1_rd_en,
    output wr_en, din
  );

  modport slave (
    output fifo0_dout, fifo0_empty,
    output fifo1_dout, fifo1_empty,
    output full,
    input  fifo0_rd_en, fifo1_rd_en,
    input  wr_en, din
  );

endinterface

// File: rtl/eth_txsched_rr.sv
// Two-way round-robin pick: lone requester wins,
// on contention the pointer decides.
module eth_txsched_rr (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    grant = 1'b0;
    unique case (1'b1)
      (req == 2'b11):        grant = ptr;
      (req[1] && !req[0]):   grant = 1'b1;
      default:               grant = 1'b0;
    endcase
  end

  assign valid = |req;

endmodule

// File: rtl/eth_txsched.sv
// Packet-aware RR scheduler: src0/src1 FWFT FIFOs -> arb2encap FIFO.
// Stats counters built only with ETH_TXSCHED_STATS_EN defined.
module eth_txsched
  import eth_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int KEEP_W    = 8,
  parameter int WORD_W    = DATA_W + KEEP_W + 2,
  parameter int MAX_WORDS = 1024,
  parameter int CNT_W     = 32
) (
  input  logic             clk156,
  input  logic             sys_rst_n,
  eth_txsched_if.master    fifo,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1,
  output logic [15:0]      trunc_cnt,
  output logic             busy
);

  localparam int LAST_B = DATA_W + KEEP_W;
  localparam int USER_B = LAST_B + 1;
  localparam int WC_W   = $clog2(MAX_WORDS);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MAX_WORDS - 1);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_XFER  = XFER;
  localparam logic [1:0] S_DRAIN = DRAIN;

  logic [1:0]        state;
  logic              rr_ptr;
  logic              grant;
  logic [WC_W-1:0]   wcnt;
  logic              rr_grant;
  logic              rr_valid;
  logic [WORD_W-1:0] head;
  logic              src_empty;
  logic              head_last;
  logic              beat;
  logic              trunc;
  logic              dpop;
  logic              pop;

  eth_txsched_rr u_rr (
    .req   ({!fifo.fifo1_empty, !fifo.fifo0_empty}),
    .ptr   (rr_ptr),
    .grant (rr_grant),
    .valid (rr_valid)
  );

  assign head      = grant ? fifo.fifo1_dout : fifo.fifo0_dout;
  assign src_empty = grant ? fifo.fifo1_empty : fifo.fifo0_empty;
  assign head_last = head[LAST_B];

  assign beat  = (state == S_XFER) && !src_empty && !fifo.full;
  assign trunc = beat && !head_last && (wcnt == WC_MAX);
  assign dpop  = (state == S_DRAIN) && !src_empty;
  assign pop   = beat || dpop;

  assign fifo.fifo0_rd_en = pop && !grant;
  assign fifo.fifo1_rd_en = pop && grant;
  assign fifo.wr_en       = beat;
  assign busy             = (state != S_IDLE);

  // A truncated packet is closed off and flagged as errored downstream
  always_comb begin
    fifo.din = head;
    if (trunc) begin
      fifo.din[LAST_B] = 1'b1;
      fifo.din[USER_B] = 1'b1;
    end
  end

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state  <= S_IDLE;
      rr_ptr <= 1'b0;
      grant  <= 1'b0;
      wcnt   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (rr_valid) begin
            grant <= rr_grant;
            wcnt  <= '0;
            state <= S_XFER;
          end
        end
        S_XFER: begin
          if (beat) begin
            if (head_last) begin
              state  <= S_IDLE;
              rr_ptr <= ~grant;
              wcnt   <= '0;
            end else if (trunc) begin
              state <= S_DRAIN;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (dpop && head_last) begin
            state  <= S_IDLE;
            rr_ptr <= ~grant;
            wcnt   <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ETH_TXSCHED_STATS_EN
  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pkt_cnt0  <= '0;
      pkt_cnt1  <= '0;
      trunc_cnt <= '0;
    end else begin
      if (beat && head_last) begin
        if (grant) pkt_cnt1 <= pkt_cnt1 + 1'b1;
        else       pkt_cnt0 <= pkt_cnt0 + 1'b1;
      end
      if (trunc && trunc_cnt != 16'hFFFF)
        trunc_cnt <= trunc_cnt + 1'b1;
    end
  end
`else
  assign pkt_cnt0  = '0;
  assign pkt_cnt1  = '0;
  assign trunc_cnt = '0;
`endif

endmodule

// File: tb/tb_eth_txsched.sv
// Directed bench for eth_txsched (MAX_WORDS=4) with FIFO queue models.
// Counter expectations follow ETH_TXSCHED_STATS_EN.
module tb_eth_txsched;
  import eth_pkg::*;

  localparam int W = ETH_WORD_W;
`ifdef ETH_TXSCHED_STATS_EN
  localparam int ST = 1;
`else
  localparam int ST = 0;
`endif

  logic        clk156 = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [31:0] pkt_cnt0;
  logic [31:0] pkt_cnt1;
  logic [15:0] trunc_cnt;
  logic        busy;

  eth_txsched_if #(.WORD_W(W)) bus ();

  eth_txsched #(.MAX_WORDS(4)) dut (
    .clk156    (clk156),
    .sys_rst_n (sys_rst_n),
    .fifo      (bus.master),
    .pkt_cnt0  (pkt_cnt0),
    .pkt_cnt1  (pkt_cnt1),
    .trunc_cnt (trunc_cnt),
    .busy      (busy)
  );

  always #5 clk156 = ~clk156;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [W-1:0] outq[$];
  logic [W-1:0] expq[$];
  logic         rd0_s, rd1_s, wr_s;
  logic [W-1:0] din_s;
  int           checks = 0;
  int           errors = 0;

  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(int src, int idx, bit last);
    logic [W-1:0] w;
    w = '0;
    w[63:0]  = {16'hDA7A, 8'(src), 8'(idx), 32'h1234_5678 ^ 32'(idx)};
    w[71:64] = 8'hFF;
    w[72]    = last;
    return w;
  endfunction

  task automatic upd();
    bus.fifo0_empty = (q0.size() == 0);
    bus.fifo1_empty = (q1.size() == 0);
    bus.fifo0_dout  = (q0.size() != 0) ? q0[0] : '0;
    bus.fifo1_dout  = (q1.size() != 0) ? q1[0] : '0;
  endtask

  task automatic load(int src, int n);
    for (int i = 0; i < n; i++) begin
      if (src == 0) q0.push_back(mk(0, i, i == n - 1));
      else          q1.push_back(mk(1, i, i == n - 1));
    end
    upd();
  endtask

  task automatic step();
    @(negedge clk156);
    rd0_s = bus.fifo0_rd_en;
    rd1_s = bus.fifo1_rd_en;
    wr_s  = bus.wr_en;
    din_s = bus.din;
    check("dual_rd", 128'(rd0_s & rd1_s), 0);
    @(posedge clk156);
    #1;
    if (rd0_s && q0.size() != 0) void'(q0.pop_front());
    if (rd1_s && q1.size() != 0) void'(q1.pop_front());
    if (wr_s) outq.push_back(din_s);
    upd();
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    q0.delete();
    q1.delete();
    outq.delete();
    bus.full = 1'b0;
    upd();
    repeat (2) @(posedge clk156);
    #1;
    sys_rst_n = 1'b1;
  endtask

  logic [W-1:0] tw;

  initial begin
    bus.full = 1'b0;
    upd();
    do_reset();

    check("rst_state", 128'(dut.state), 0);
    check("rst_busy", 128'(busy), 0);
    check("rst_wr", 128'(bus.wr_en), 0);
    check("rst_cnt", {pkt_cnt0, pkt_cnt1, trunc_cnt}, 0);

    // 1: single 3-word packet from src0
    load(0, 3);
    step();
    check("t1_bubble", 128'(wr_s), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t1_wr", 128'(wr_s), 1);
      check("t1_din", din_s, mk(0, i, i == 2));
    end
    check("t1_last", 128'(din_s[72]), 1);
    check("t1_pkt0", pkt_cnt0, ST);
    check("t1_rr", 128'(dut.rr_ptr), 1);
    check("t1_idle", 128'(busy), 0);

    // 2: both sources, src0 first with a gap between packets
    do_reset();
    load(0, 2);
    load(1, 2);
    begin
      bit pat [6] = '{0, 1, 1, 0, 1, 1};
      for (int i = 0; i < 6; i++) begin
        step();
        check("t2_wr", 128'(wr_s), 128'(pat[i]));
      end
    end
    expq = '{mk(0, 0, 0), mk(0, 1, 1), mk(1, 0, 0), mk(1, 1, 1)};
    check("t2_len", outq.size(), 4);
    for (int i = 0; i < 4 && i < outq.size(); i++)
      check("t2_sb", outq[i], expq[i]);
    check("t2_pkt0", pkt_cnt0, ST);
    check("t2_pkt1", pkt_cnt1, ST);

    // 3: full stall for 5 cycles mid-packet
    outq.delete();
    load(0, 3);
    step();
    step();
    check("t3_w0", 128'(wr_s), 1);
    bus.full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_stall", 128'({rd0_s, rd1_s, wr_s}), 0);
    end
    bus.full = 1'b0;
    step();
    step();
    expq = '{mk(0, 0, 0), mk(0, 1, 0), mk(0, 2, 1)};
    check("t3_len", outq.size(), 3);
    for (int i = 0; i < 3 && i < outq.size(); i++)
      check("t3_sb", outq[i], expq[i]);

    // 4: 7-word packet from src1 truncated at 4 words
    do_reset();
    load(1, 7);
    step();
    check("t4_bubble", 128'(wr_s), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      tw = mk(1, i, 0);
      if (i == 3) tw[73:72] = 2'b11;
      check("t4_wr", 128'(wr_s), 1);
      check("t4_din", din_s, tw);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_drain", 128'({rd1_s, wr_s}), 128'(2'b10));
    end
    step();
    check("t4_q1", q1.size(), 0);
    check("t4_idle", 128'(busy), 0);
    check("t4_trunc", trunc_cnt, ST);
    check("t4_pkt1", pkt_cnt1, 0);

    // 5: async reset mid-transfer
    load(0, 3);
    step();
    step();
    check("t5_xfer", 128'(wr_s), 1);
    sys_rst_n = 1'b0;
    #1;
    check("t5_rd", 128'({bus.fifo0_rd_en, bus.fifo1_rd_en}), 0);
    check("t5_wr", 128'(bus.wr_en), 0);
    check("t5_state", 128'(dut.state), 0);
    check("t5_cnt", {pkt_cnt0, pkt_cnt1, trunc_cnt}, 0);
    @(posedge clk156);
    #1;
    q0.delete();
    outq.delete();
    upd();
    sys_rst_n = 1'b1;
    load(0, 2);
    load(1, 2);
    step();
    check("t5_bubble", 128'(wr_s), 0);
    step();
    check("t5_first", din_s, mk(0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
